// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the 3-stage pipeline hazard sequencer.
// Holds the opcode group codes (opcode[7:3]), the FSM state codes and the
// opcode classification functions used by the decoders.
package pipe_pkg;

  // FSM state codes as they appear on the state output
  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_FLUSH = 2'd1;
  localparam logic [1:0] ST_STALL = 2'd2;

  typedef enum logic [1:0] {
    S_RUN   = ST_RUN,
    S_FLUSH = ST_FLUSH,
    S_STALL = ST_STALL
  } state_e;

  // Opcode groups, keyed on opcode[7:3]; opcode[2:0] is the register field rrr
  localparam logic [4:0] OP_UNC = 5'b0000_0; // rrr 3..7: unconditional JUA/CUA/...
  localparam logic [4:0] OP_JCD = 5'b0000_1; // conditional transfer
  localparam logic [4:0] OP_NOT = 5'b0001_0;
  localparam logic [4:0] OP_DCR = 5'b0001_1;
  localparam logic [4:0] OP_JZ  = 5'b0010_1; // conditional transfer
  localparam logic [4:0] OP_JNZ = 5'b0011_0; // conditional transfer
  localparam logic [4:0] OP_JN  = 5'b0011_1; // conditional transfer
  localparam logic [4:0] OP_INC = 5'b0100_0;
  localparam logic [4:0] OP_CCD = 5'b0100_1; // conditional transfer
  localparam logic [4:0] OP_STA = 5'b0101_0;
  localparam logic [4:0] OP_PSH = 5'b0101_1;
  localparam logic [4:0] OP_MVS = 5'b0110_0;
  localparam logic [4:0] OP_LDA = 5'b0111_0;
  localparam logic [4:0] OP_POP = 5'b0111_1;
  localparam logic [4:0] OP_RLA = 5'b1111_0;
  localparam logic [4:0] OP_RRA = 5'b1111_1;

  // ALU block occupies opcode[7:4] = 1000..1110
  function automatic logic is_alu(input logic [7:0] op);
    return op[7] && (op[6:4] != 3'b111);
  endfunction

  // Control transfer that is taken given the evaluated condition flag
  function automatic logic is_xfer(input logic [7:0] op, input logic flag);
    logic r;
    r = 1'b0;
    case (op[7:3])
      OP_UNC:                             r = (op[2:0] >= 3'd3);
      OP_JCD, OP_JZ, OP_JNZ, OP_JN, OP_CCD: r = flag;
      default:                            r = 1'b0;
    endcase
    return r;
  endfunction

  // Instructions whose result lands late in register rn = opcode[2:0]
  function automatic logic is_load(input logic [7:0] op);
    logic r;
    r = 1'b0;
    case (op[7:3])
      OP_LDA:  r = (op[2:0] != 3'd0);
      OP_POP:  r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // Instructions that read register rn = opcode[2:0] in decode
  function automatic logic reads_rn(input logic [7:0] op);
    logic r;
    r = 1'b0;
    case (op[7:3])
      OP_NOT, OP_DCR, OP_INC, OP_PSH: r = 1'b1;
      OP_STA, OP_MVS:                 r = (op[2:0] != 3'd0);
      default:                        r = is_alu(op) && !op[3];
    endcase
    return r;
  endfunction

  // Instructions that read the accumulator R0
  function automatic logic reads_acc(input logic [7:0] op);
    return is_alu(op) || (op[7:3] == OP_RLA) || (op[7:3] == OP_RRA);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_op_decode.sv
// Combinational opcode classifier; one instance per watched pipeline slot.
// Every class bit is qualified by the slot's valid so a bubble never raises a hazard.
module pipe_op_decode
  import pipe_pkg::*;
(
  input  logic       valid_i,
  input  logic [7:0] opcode_i,
  input  logic       flag_i,
  output logic       xfer_o,
  output logic       load_o,
  output logic       reads_rn_o,
  output logic       reads_acc_o,
  output logic [2:0] rn_o
);

  // Class bits straight from the package functions, masked by valid
  always_comb begin
    xfer_o      = valid_i && is_xfer(opcode_i, flag_i);
    load_o      = valid_i && is_load(opcode_i);
    reads_rn_o  = valid_i && reads_rn(opcode_i);
    reads_acc_o = valid_i && reads_acc(opcode_i);
    rn_o        = opcode_i[2:0];
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard sequencer for the fetch / decode / execute pipeline.
// A taken transfer in execute flushes decode and execute for FLUSH_CYCLES cycles;
// a load-use RAW hazard holds PC/decode and bubbles execute for LOAD_LAT cycles.
// The first bubble cycle is the detection cycle itself (Mealy outputs in RUN);
// FLUSH/STALL cover the remaining N-1 cycles, so N=1 never leaves RUN.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int LOAD_LAT     = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [7:0]       id_opcode,
  input  logic             ex_valid,
  input  logic [7:0]       ex_opcode,
  input  logic             ex_flag,
  output logic             hold_pc,
  output logic             hold_id,
  output logic             flush_id,
  output logic             flush_ex,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // Down-counter preload: cycles left in FLUSH/STALL after the first one, minus one
  localparam logic [1:0] FL_PRELOAD = (FLUSH_CYCLES > 1) ? 2'(FLUSH_CYCLES - 2) : 2'd0;
  localparam logic [1:0] LD_PRELOAD = (LOAD_LAT > 1) ? 2'(LOAD_LAT - 2) : 2'd0;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  state_e           state_q, state_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             hold_pc_c, hold_id_c, flush_id_c, flush_ex_c;

  logic       id_xfer, id_load, id_rd_rn, id_rd_acc;
  logic       ex_xfer, ex_load, ex_rd_rn, ex_rd_acc;
  logic [2:0] id_rn, ex_rn;
  logic       lu_hit;
  logic       unused_dec;

  pipe_op_decode u_id_dec (
    .valid_i     (id_valid),
    .opcode_i    (id_opcode),
    .flag_i      (1'b0),
    .xfer_o      (id_xfer),
    .load_o      (id_load),
    .reads_rn_o  (id_rd_rn),
    .reads_acc_o (id_rd_acc),
    .rn_o        (id_rn)
  );

  pipe_op_decode u_ex_dec (
    .valid_i     (ex_valid),
    .opcode_i    (ex_opcode),
    .flag_i      (ex_flag),
    .xfer_o      (ex_xfer),
    .load_o      (ex_load),
    .reads_rn_o  (ex_rd_rn),
    .reads_acc_o (ex_rd_acc),
    .rn_o        (ex_rn)
  );

  // Only the consumer side of id and the producer side of ex matter here
  assign unused_dec = ^{id_xfer, id_load, ex_rd_rn, ex_rd_acc};

  // Load in execute whose destination is read by the decode instruction
  always_comb begin
    lu_hit = ex_load && ((id_rd_rn && (id_rn == ex_rn)) ||
                         (id_rd_acc && (ex_rn == 3'd0)));
  end

  // Next state, down-counter, perf counters and Mealy control outputs
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    hold_pc_c   = 1'b0;
    hold_id_c   = 1'b0;
    flush_id_c  = 1'b0;
    flush_ex_c  = 1'b0;
    case (state_q)
      S_RUN: begin
        if (ex_xfer) begin
          flush_id_c  = 1'b1;
          flush_ex_c  = 1'b1;
          flush_cnt_d = sat_inc(flush_cnt_q);
          if (FLUSH_CYCLES > 1) begin
            state_d = S_FLUSH;
            cnt_d   = FL_PRELOAD;
          end
        end else if (lu_hit) begin
          hold_pc_c   = 1'b1;
          hold_id_c   = 1'b1;
          flush_ex_c  = 1'b1;
          stall_cnt_d = sat_inc(stall_cnt_q);
          if (LOAD_LAT > 1) begin
            state_d = S_STALL;
            cnt_d   = LD_PRELOAD;
          end
        end
      end
      S_FLUSH: begin
        flush_id_c = 1'b1;
        flush_ex_c = 1'b1;
        if (cnt_q == 2'd0) state_d = S_RUN;
        else               cnt_d   = cnt_q - 2'd1;
      end
      S_STALL: begin
        hold_pc_c   = 1'b1;
        hold_id_c   = 1'b1;
        flush_ex_c  = 1'b1;
        stall_cnt_d = sat_inc(stall_cnt_q);
        if (cnt_q == 2'd0) state_d = S_RUN;
        else               cnt_d   = cnt_q - 2'd1;
      end
      default: state_d = S_RUN;
    endcase
  end

  // State and counter registers; reset aborts any sequence in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_RUN;
      cnt_q       <= 2'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // RUN outputs follow the inputs, so reset must also mask them directly
  always_comb begin
    hold_pc  = hold_pc_c  && !rst;
    hold_id  = hold_id_c  && !rst;
    flush_id = flush_id_c && !rst;
    flush_ex = flush_ex_c && !rst;
  end

  assign state     = state_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl. Two instances share the same stimulus:
//   dut 0: FLUSH_CYCLES=2, LOAD_LAT=1, CNT_W=16
//   dut 1: FLUSH_CYCLES=3, LOAD_LAT=3, CNT_W=4 (short counters to reach saturation)
// Reference model: per instance, a count of bubble cycles still owed and their kind,
// plus opcode classes written as opcode value ranges.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       id_valid = 1'b0;
  logic [7:0] id_opcode = 8'h00;
  logic       ex_valid = 1'b0;
  logic [7:0] ex_opcode = 8'h00;
  logic       ex_flag = 1'b0;

  logic        hp_w[2];
  logic        hi_w[2];
  logic        fi_w[2];
  logic        fe_w[2];
  logic [1:0]  st_w[2];
  logic [15:0] sc_w[2];
  logic [15:0] fc_w[2];
  logic [3:0]  b_sc, b_fc;

  int total = 0;
  int bad   = 0;

  // Model state
  int m_busy[2];
  int m_kind[2];  // 1 = flush, 2 = stall
  int m_scnt[2];
  int m_fcnt[2];
  int m_fl[2]  = '{2, 3};
  int m_ld[2]  = '{1, 3};
  int m_sat[2] = '{65535, 15};

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.FLUSH_CYCLES(2), .LOAD_LAT(1), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_opcode(id_opcode),
    .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_flag(ex_flag),
    .hold_pc(hp_w[0]), .hold_id(hi_w[0]), .flush_id(fi_w[0]), .flush_ex(fe_w[0]),
    .state(st_w[0]), .stall_cnt(sc_w[0]), .flush_cnt(fc_w[0])
  );

  pipe_hazard_ctrl #(.FLUSH_CYCLES(3), .LOAD_LAT(3), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_opcode(id_opcode),
    .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_flag(ex_flag),
    .hold_pc(hp_w[1]), .hold_id(hi_w[1]), .flush_id(fi_w[1]), .flush_ex(fe_w[1]),
    .state(st_w[1]), .stall_cnt(b_sc), .flush_cnt(b_fc)
  );

  assign sc_w[1] = {12'h000, b_sc};
  assign fc_w[1] = {12'h000, b_fc};

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Opcode classes as value ranges
  function automatic bit m_xfer(input logic [7:0] o, input logic f);
    return (o inside {[8'h03:8'h07]}) ||
           (f && (o inside {[8'h08:8'h0F], [8'h28:8'h3F], [8'h48:8'h4F]}));
  endfunction
  function automatic bit m_load(input logic [7:0] o);
    return o inside {[8'h71:8'h7F]};
  endfunction
  function automatic bit m_rd_rn(input logic [7:0] o);
    return (o inside {[8'h10:8'h1F], [8'h40:8'h47], [8'h51:8'h5F], [8'h61:8'h67]}) ||
           ((o inside {[8'h80:8'hEF]}) && !o[3]);
  endfunction
  function automatic bit m_rd_acc(input logic [7:0] o);
    return o >= 8'h80;
  endfunction

  // {taken transfer, load-use hit} seen on the current inputs
  function automatic logic [1:0] m_hazard();
    bit x, h;
    x = ex_valid && m_xfer(ex_opcode, ex_flag);
    h = ex_valid && id_valid && m_load(ex_opcode) &&
        ((m_rd_rn(id_opcode) && id_opcode[2:0] == ex_opcode[2:0]) ||
         (m_rd_acc(id_opcode) && ex_opcode[2:0] == 3'd0));
    return {x, h && !x};
  endfunction

  // Model advance at each edge
  always @(posedge clk or posedge rst) begin
    logic [1:0] hz;
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        m_busy[k] = 0; m_kind[k] = 0; m_scnt[k] = 0; m_fcnt[k] = 0;
      end
    end else begin
      hz = m_hazard();
      for (int k = 0; k < 2; k++) begin
        if (m_busy[k] > 0) begin
          if (m_kind[k] == 2 && m_scnt[k] < m_sat[k]) m_scnt[k]++;
          m_busy[k]--;
        end else if (hz[1]) begin
          if (m_fcnt[k] < m_sat[k]) m_fcnt[k]++;
          m_busy[k] = m_fl[k] - 1;
          m_kind[k] = 1;
        end else if (hz[0]) begin
          if (m_scnt[k] < m_sat[k]) m_scnt[k]++;
          m_busy[k] = m_ld[k] - 1;
          m_kind[k] = 2;
        end
      end
    end
  end

  // Compare every cycle, mid-cycle
  always @(negedge clk) begin
    logic [1:0] hz;
    bit e_hold, e_flid, e_flex;
    int e_st;
    if (!rst) begin
      hz = m_hazard();
      for (int k = 0; k < 2; k++) begin
        if (m_busy[k] > 0) begin
          e_st   = m_kind[k];
          e_hold = (m_kind[k] == 2);
          e_flid = (m_kind[k] == 1);
        end else begin
          e_st   = 0;
          e_hold = hz[0];
          e_flid = hz[1];
        end
        e_flex = e_hold || e_flid;
        chk($sformatf("dut%0d.hold_pc", k),   32'(hp_w[k]), 32'(e_hold));
        chk($sformatf("dut%0d.hold_id", k),   32'(hi_w[k]), 32'(e_hold));
        chk($sformatf("dut%0d.flush_id", k),  32'(fi_w[k]), 32'(e_flid));
        chk($sformatf("dut%0d.flush_ex", k),  32'(fe_w[k]), 32'(e_flex));
        chk($sformatf("dut%0d.state", k),     32'(st_w[k]), 32'(e_st));
        chk($sformatf("dut%0d.stall_cnt", k), 32'(sc_w[k]), 32'(m_scnt[k]));
        chk($sformatf("dut%0d.flush_cnt", k), 32'(fc_w[k]), 32'(m_fcnt[k]));
        chk($sformatf("dut%0d.hold_and_flush", k), 32'(hp_w[k] & fi_w[k]), 32'd0);
      end
    end
  end

  task automatic drive(input logic iv, input logic [7:0] iop,
                       input logic ev, input logic [7:0] eop, input logic fl);
    @(posedge clk);
    #1;
    id_valid = iv; id_opcode = iop; ex_valid = ev; ex_opcode = eop; ex_flag = fl;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    mid();
    chk("rst.state",     32'(st_w[0]), 32'd0);
    chk("rst.hold_pc",   32'(hp_w[0]), 32'd0);
    chk("rst.flush_ex",  32'(fe_w[0]), 32'd0);
    chk("rst.stall_cnt", 32'(sc_w[0]), 32'd0);
    chk("rst.flush_cnt", 32'(fc_w[1]), 32'd0);

    // 1: unconditional JUA
    drive(1'b0, 8'h00, 1'b1, 8'h04, 1'b0); mid();
    chk("t1.c0.flush_id", 32'(fi_w[0]), 32'd1);
    chk("t1.c0.state",    32'(st_w[0]), 32'd0);
    idle(1); mid();
    chk("t1.c1.flush_ex", 32'(fe_w[0]), 32'd1);
    chk("t1.c1.state",    32'(st_w[0]), 32'd1);
    idle(1); mid();
    chk("t1.c2.flush_id", 32'(fi_w[0]), 32'd0);
    chk("t1.c2.state",    32'(st_w[0]), 32'd0);
    chk("t1.flush_cnt",   32'(fc_w[0]), 32'd1);
    idle(2);

    // 2: JCD, flag clear then set
    drive(1'b0, 8'h00, 1'b1, 8'h0B, 1'b0); mid();
    chk("t2.nf.flush_ex", 32'(fe_w[0]), 32'd0);
    drive(1'b0, 8'h00, 1'b1, 8'h0B, 1'b1); mid();
    chk("t2.f.flush_ex",  32'(fe_w[0]), 32'd1);
    idle(3); mid();
    chk("t2.flush_cnt",   32'(fc_w[0]), 32'd2);

    // masking: invalid ex transfer, invalid id consumer
    drive(1'b0, 8'h00, 1'b0, 8'h04, 1'b0); mid();
    chk("mask.ex.flush_id", 32'(fi_w[0]), 32'd0);
    drive(1'b0, 8'h43, 1'b1, 8'h73, 1'b0); mid();
    chk("mask.id.hold_pc",  32'(hp_w[0]), 32'd0);

    // 3: LDA r3 -> INC r3
    drive(1'b1, 8'h43, 1'b1, 8'h73, 1'b0); mid();
    chk("t3.hold_pc",  32'(hp_w[0]), 32'd1);
    chk("t3.hold_id",  32'(hi_w[0]), 32'd1);
    chk("t3.flush_id", 32'(fi_w[0]), 32'd0);
    idle(1); mid();
    chk("t3.after.hold_pc", 32'(hp_w[0]), 32'd0);
    chk("t3.stall_cnt",     32'(sc_w[0]), 32'd1);
    chk("t3.b.state",       32'(st_w[1]), 32'd2);
    idle(3);

    // 4: POP r2 vs ADA r1 (no hit), POP r0 vs ADA r1 (acc hit)
    drive(1'b1, 8'h81, 1'b1, 8'h7A, 1'b0); mid();
    chk("t4.r2.hold_pc", 32'(hp_w[0]), 32'd0);
    drive(1'b1, 8'h81, 1'b1, 8'h78, 1'b0); mid();
    chk("t4.r0.hold_pc", 32'(hp_w[0]), 32'd1);
    idle(1); mid();
    chk("t4.stall_cnt",  32'(sc_w[0]), 32'd2);
    idle(3);

    // 5: transfer and consumer together: flush, no stall
    drive(1'b1, 8'h43, 1'b1, 8'h06, 1'b0); mid();
    chk("t5.flush_id", 32'(fi_w[0]), 32'd1);
    chk("t5.hold_pc",  32'(hp_w[0]), 32'd0);
    idle(1); mid();
    chk("t5.stall_cnt", 32'(sc_w[0]), 32'd2);
    chk("t5.flush_cnt", 32'(fc_w[0]), 32'd3);
    idle(3);

    // 6: reset while dut_b is in FLUSH, with a transfer still presented
    drive(1'b0, 8'h00, 1'b1, 8'h04, 1'b0);
    idle(1);
    chk("t6.pre.b.state", 32'(st_w[1]), 32'd1);
    #2;
    ex_valid = 1'b1; ex_opcode = 8'h04;
    rst = 1'b1;
    #1;
    chk("t6.b.state",     32'(st_w[1]), 32'd0);
    chk("t6.b.flush_id",  32'(fi_w[1]), 32'd0);
    chk("t6.b.flush_ex",  32'(fe_w[1]), 32'd0);
    chk("t6.a.flush_id",  32'(fi_w[0]), 32'd0);
    chk("t6.b.flush_cnt", 32'(fc_w[1]), 32'd0);
    chk("t6.a.stall_cnt", 32'(sc_w[0]), 32'd0);
    ex_valid = 1'b0; ex_opcode = 8'h00;
    #2 rst = 1'b0;

    // saturation: continuous POP r0 -> ADA r1
    for (int i = 0; i < 40; i++) drive(1'b1, 8'h81, 1'b1, 8'h78, 1'b0);
    idle(1); mid();
    chk("sat.b.stall_cnt", 32'(sc_w[1]), 32'd15);
    chk("sat.a.stall_cnt", 32'(sc_w[0]), 32'd40);
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
